// File: rtl/cv32e40p_apu_wb_buffer.sv
// APU result write-back buffer: DEPTH-entry in-order FIFO draining into a shared register-file write port.
// Optional write-back stall counter enabled by macro CV32E40P_APU_WB_PERF_EN.
module cv32e40p_apu_wb_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        apu_rvalid_i,
  output logic        apu_rready_o,
  input  logic [5:0]  apu_rtag_i,
  input  logic [31:0] apu_result_i,
  input  logic [4:0]  apu_flags_i,
  input  logic        wb_port_busy_i,
  output logic        apu_valid_o,
  output logic [5:0]  apu_waddr_o,
  output logic [31:0] apu_result_o,
  output logic        fflags_we_o,
  output logic [4:0]  fflags_o,
  output logic        empty_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] result;
    logic [4:0]  flags;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  occ_e            state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic            empty, full, push, pop;

  assign empty = (state_q == OCC_EMPTY);
  assign full  = (state_q == OCC_FULL);
  assign push  = apu_rvalid_i && !full;
  assign pop   = !empty && !wb_port_busy_i;
  assign head  = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    state_d = state_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (count_d == '0)                state_d = OCC_EMPTY;
    else if (count_d == CW'(DEPTH))   state_d = OCC_FULL;
    else                              state_d = OCC_PARTIAL;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OCC_EMPTY;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset: outputs are masked to zero while empty
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wptr_q] <= '{tag: apu_rtag_i, result: apu_result_i, flags: apu_flags_i};
  end

  assign apu_rready_o = !full;
  assign apu_valid_o  = pop;
  assign fflags_we_o  = pop;
  assign empty_o      = empty;
  assign apu_waddr_o  = empty ? '0 : head.tag;
  assign apu_result_o = empty ? '0 : head.result;
  assign fflags_o     = empty ? '0 : head.flags;

`ifdef CV32E40P_APU_WB_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (!empty && wb_port_busy_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_wb_buffer.sv
// Randomised and directed bench for cv32e40p_apu_wb_buffer against a queue-based reference model.
module tb_cv32e40p_apu_wb_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, rvalid, busy;
  logic [5:0]  tag;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        apu_rready_o, apu_valid_o, fflags_we_o, empty_o;
  logic [5:0]  apu_waddr_o;
  logic [31:0] apu_result_o, stall_cnt_o;
  logic [4:0]  fflags_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [42:0] mq[$];
  logic [31:0] stall_m = '0;

  always #5 clk = ~clk;

  cv32e40p_apu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .apu_rvalid_i   (rvalid),
    .apu_rready_o   (apu_rready_o),
    .apu_rtag_i     (tag),
    .apu_result_i   (result),
    .apu_flags_i    (flags),
    .wb_port_busy_i (busy),
    .apu_valid_o    (apu_valid_o),
    .apu_waddr_o    (apu_waddr_o),
    .apu_result_o   (apu_result_o),
    .fflags_we_o    (fflags_we_o),
    .fflags_o       (fflags_o),
    .empty_o        (empty_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  function automatic logic [78:0] exp_vec();
    logic [42:0] h;
    logic        e, p;
    e = (mq.size() == 0);
    h = e ? '0 : mq[0];
    p = !e && !busy;
    return {p, h[42:37], h[36:5], p, h[4:0], e, (mq.size() != DEPTH), stall_m};
  endfunction

  function automatic logic [78:0] obs_vec();
    return {apu_valid_o, apu_waddr_o, apu_result_o, fflags_we_o, fflags_o,
            empty_o, apu_rready_o, stall_cnt_o};
  endfunction

  // Advance one clock, updating the reference model from the inputs seen at the edge.
  task automatic tick();
    bit e, do_push, do_pop;
    e       = (mq.size() == 0);
    do_push = rvalid && (mq.size() < DEPTH);
    do_pop  = !e && !busy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      stall_m = '0;
    end else begin
`ifdef CV32E40P_APU_WB_PERF_EN
      if (!e && busy && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
`endif
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({tag, result, flags});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rvalid = 1'b1; busy = 1'b0;
    tag = 6'h2A; result = 32'h1234_5678; flags = 5'h1F;
    tick();
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_hold obs=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    n_checks++;
    if ({apu_valid_o, fflags_we_o, empty_o, apu_rready_o, apu_waddr_o, apu_result_o, fflags_o, stall_cnt_o} !== {4'b0011, 75'd0})
      $display("FAIL reset_values valid=%b we=%b empty=%b rready=%b addr=%h res=%h ff=%h stall=%h exp valid=0 we=0 empty=1 rready=1 zeros",
               apu_valid_o, fflags_we_o, empty_o, apu_rready_o, apu_waddr_o, apu_result_o, fflags_o, stall_cnt_o);
    else n_pass++;
    rst = 1'b0; rvalid = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_release obs=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_single();
    rvalid = 1'b1; busy = 1'b0; tag = 6'h25; result = 32'hDEAD_BEEF; flags = 5'h01;
    #1;
    n_checks++;
    if (apu_valid_o !== 1'b0) $display("FAIL single_nobypass valid=%b exp=0", apu_valid_o);
    else n_pass++;
    tick();
    rvalid = 1'b0;
    #1;
    n_checks++;
    if ({apu_valid_o, apu_waddr_o, apu_result_o, fflags_we_o, fflags_o} !== {1'b1, 6'h25, 32'hDEAD_BEEF, 1'b1, 5'h01})
      $display("FAIL single_wb valid=%b addr=%h res=%h we=%b ff=%h exp 1 25 deadbeef 1 01",
               apu_valid_o, apu_waddr_o, apu_result_o, fflags_we_o, fflags_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({apu_valid_o, empty_o} !== 2'b01) $display("FAIL single_once valid=%b empty=%b exp 0 1", apu_valid_o, empty_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [5:0] want [2];
    want[0] = 6'h11; want[1] = 6'h22;
    busy = 1'b1; rvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tag = want[i]; result = {26'd0, want[i]}; flags = 5'(i);
      #1;
      tick();
    end
    tag = 6'h33; result = 32'h33; flags = 5'h3;
    #1;
    n_checks++;
    if (apu_rready_o !== 1'b0) $display("FAIL bp_rready rready=%b exp=0", apu_rready_o);
    else n_pass++;
    tick();
    rvalid = 1'b0; busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({apu_valid_o, apu_waddr_o, apu_result_o} !== {1'b1, want[i], {26'd0, want[i]}})
        $display("FAIL bp_order%0d valid=%b addr=%h res=%h exp 1 %h", i, apu_valid_o, apu_waddr_o, apu_result_o, want[i]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({apu_valid_o, empty_o} !== 2'b01) $display("FAIL bp_drop_third valid=%b empty=%b exp 0 1", apu_valid_o, empty_o);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] want_stall;
`ifdef CV32E40P_APU_WB_PERF_EN
    want_stall = 32'd3;
`else
    want_stall = 32'd0;
`endif
    rst = 1'b1; rvalid = 1'b0; busy = 1'b1;
    tick();
    rst = 1'b0; rvalid = 1'b1; tag = 6'h07; result = 32'hCAFE_0007; flags = 5'h04;
    #1;
    tick();
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({apu_valid_o, apu_waddr_o, apu_result_o, fflags_o} !== {1'b0, 6'h07, 32'hCAFE_0007, 5'h04})
        $display("FAIL stall_hold%0d valid=%b addr=%h res=%h ff=%h exp 0 07 cafe0007 04",
                 i, apu_valid_o, apu_waddr_o, apu_result_o, fflags_o);
      else n_pass++;
      tick();
    end
    busy = 1'b0;
    #1;
    n_checks++;
    if ({apu_valid_o, apu_waddr_o, stall_cnt_o} !== {1'b1, 6'h07, want_stall})
      $display("FAIL stall_release valid=%b addr=%h stall=%0d exp 1 07 %0d", apu_valid_o, apu_waddr_o, stall_cnt_o, want_stall);
    else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    busy = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      rvalid = (i < 10);
      tag = 6'(i + 32); result = 32'(i); flags = 5'(i);
      #1;
      if (i > 0) begin
        n_checks++;
        if ({apu_valid_o, apu_result_o, apu_waddr_o, empty_o, apu_rready_o} !== {1'b1, 32'(i - 1), 6'(i + 31), 2'b01})
          $display("FAIL stream%0d valid=%b res=%0d addr=%h empty=%b rready=%b exp 1 %0d %h 0 1",
                   i, apu_valid_o, apu_result_o, apu_waddr_o, empty_o, apu_rready_o, i - 1, 6'(i + 31));
        else n_pass++;
      end
      tick();
    end
    rvalid = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL stream_end obs=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    busy = 1'b1; rvalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tag = 6'(i + 1); result = 32'hBAD0_0000 + 32'(i); flags = 5'h1F;
      #1;
      tick();
    end
    rst = 1'b1; busy = 1'b0;
    #1;
    tick();
    rst = 1'b0; rvalid = 1'b0;
    #1;
    n_checks++;
    if ({empty_o, apu_valid_o, apu_rready_o} !== 3'b101)
      $display("FAIL rstmid_state empty=%b valid=%b rready=%b exp 1 0 1", empty_o, apu_valid_o, apu_rready_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if ({apu_valid_o, empty_o} !== 2'b01) $display("FAIL rstmid_stale valid=%b empty=%b exp 0 1", apu_valid_o, empty_o);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      rvalid = $urandom_range(0, 2) != 0;
      busy   = $urandom_range(0, 2) == 0;
      tag    = 6'($urandom);
      result = $urandom;
      flags  = 5'($urandom);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    rst = 1'b0; rvalid = 1'b0; busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stall();
    test_stream();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
